rce_codeword_receiver: RTL and testbench

- Far-end receiver for the serial codeword stream that the parallel RCE encoder's transmitter mux drives onto y.
- Deframes each codeword: K message bits followed by K_N parity bits, both MSB first.
- Message bits are deserialized into W-bit words and buffered in a small FIFO drained with a valid/ready handshake. Parity is collected into a K_N-bit register and presented once per frame.
- Sits at the link input ahead of a decoder or host interface.

---
 rtl/rce_codeword_receiver_if.sv | 48 ++++
 rtl/rce_codeword_receiver.sv | 211 +++++++++++++++++++++
 tb/tb_rce_codeword_receiver.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rce_codeword_receiver_if.sv
// Link-side bundle for the RCE codeword receiver.
// Optional macro RX_PARITY_CHECK_EN adds exp_par / par_err / err_cnt.
//
// Handshake: msg_word is transferred on a rising clk edge where
// msg_valid && msg_ready. msg_valid never depends on msg_ready, and while
// msg_valid is high msg_word holds the FIFO head until it is accepted.
// y/bit_en/sof are a qualified bit stream with no back-pressure.
interface rce_codeword_receiver_if #(
    parameter int W   = 32,
    parameter int K_N = 256
);
    logic           y;
    logic           bit_en;
    logic           sof;
    logic [W-1:0]   msg_word;
    logic           msg_valid;
    logic           msg_ready;
    logic [K_N-1:0] par_out;
    logic           par_valid;
    logic           busy;
    logic           overflow;
    logic           abort;
`ifdef RX_PARITY_CHECK_EN
    logic [K_N-1:0] exp_par;
    logic           par_err;
    logic [15:0]    err_cnt;

    modport master (
        output y, bit_en, sof, msg_ready, exp_par,
        input  msg_word, msg_valid, par_out, par_valid, busy, overflow, abort,
               par_err, err_cnt
    );
    modport slave (
        input  y, bit_en, sof, msg_ready, exp_par,
        output msg_word, msg_valid, par_out, par_valid, busy, overflow, abort,
               par_err, err_cnt
    );
`else
    modport master (
        output y, bit_en, sof, msg_ready,
        input  msg_word, msg_valid, par_out, par_valid, busy, overflow, abort
    );
    modport slave (
        input  y, bit_en, sof, msg_ready,
        output msg_word, msg_valid, par_out, par_valid, busy, overflow, abort
    );
`endif
endinterface

// File: rtl/rce_codeword_receiver.sv
// Serial codeword receiver: deframes K message bits + K_N parity bits (MSB
// first), packs message bits into W-bit words through a small FIFO and
// presents parity once per frame.
// Optional macro RX_PARITY_CHECK_EN: compares parity against exp_par and
// keeps a saturating error count.
module rce_codeword_receiver #(
    parameter int K          = 1024,
    parameter int K_N        = 256,
    parameter int W          = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    rce_codeword_receiver_if.slave bus,
    output logic [1:0]             state_dbg
);
    localparam int MCW = $clog2(K + 1);
    localparam int WCW = $clog2(W + 1);
    localparam int PCW = $clog2(K_N + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [MCW-1:0] msg_cnt;
    logic [WCW-1:0] wrd_cnt;
    logic [PCW-1:0] par_cnt;
    logic [W-1:0]   word_sr;
    logic [K_N-1:0] par_sr;
    logic [K_N-1:0] par_out_r;
    logic           par_valid_r;
    logic           abort_r;
    logic           overflow_r;

    logic           sof_hit;
    logic [MCW-1:0] msg_idx;
    logic [WCW-1:0] wrd_idx;
    logic [W-1:0]   word_base;
    logic [W-1:0]   word_shift;
    logic [K_N-1:0] par_shift;
    logic           msg_last;
    logic           word_done;
    logic           par_last;
    logic           msg_take;
    logic           par_take;
    logic           par_done;
    logic           abort_set;

    logic [W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    fifo_cnt;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_wr;
    logic           fifo_rd;
    logic           fifo_wr_ok;

    // A qualified sof restarts the frame: counters and the partial word are
    // treated as zero for the bit that arrives with it.
    assign sof_hit    = bus.bit_en && bus.sof;
    assign msg_idx    = sof_hit ? '0 : msg_cnt;
    assign wrd_idx    = sof_hit ? '0 : wrd_cnt;
    assign word_base  = sof_hit ? '0 : word_sr;
    assign word_shift = (word_base << 1) | W'(bus.y);
    assign par_shift  = (par_sr << 1) | K_N'(bus.y);
    assign msg_last   = (msg_idx == MCW'(K - 1));
    assign word_done  = (wrd_idx == WCW'(W - 1));
    assign par_last   = (par_cnt == PCW'(K_N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-bit control strobes.
    always_comb begin
        state_nxt = state;
        msg_take  = 1'b0;
        par_take  = 1'b0;
        par_done  = 1'b0;
        abort_set = 1'b0;
        if (sof_hit) begin
            msg_take  = 1'b1;
            abort_set = (state != ST_IDLE);
            state_nxt = ST_MSG;
        end else if (bus.bit_en) begin
            case (state)
                ST_MSG:  msg_take = 1'b1;
                ST_PAR:  par_take = 1'b1;
                default: ;
            endcase
        end
        if (msg_take && msg_last) begin
            state_nxt = ST_PAR;
        end
        if (par_take && par_last) begin
            par_done  = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

    // Shift registers, bit counters and per-frame parity output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_cnt     <= '0;
            wrd_cnt     <= '0;
            par_cnt     <= '0;
            word_sr     <= '0;
            par_sr      <= '0;
            par_out_r   <= '0;
            par_valid_r <= 1'b0;
            abort_r     <= 1'b0;
        end else begin
            if (msg_take) begin
                word_sr <= word_shift;
                msg_cnt <= msg_last ? '0 : msg_idx + MCW'(1);
                wrd_cnt <= word_done ? '0 : wrd_idx + WCW'(1);
            end
            if (sof_hit) begin
                par_sr  <= '0;
                par_cnt <= '0;
            end else if (par_take) begin
                par_sr  <= par_shift;
                par_cnt <= par_last ? '0 : par_cnt + PCW'(1);
            end
            if (par_done) begin
                par_out_r <= par_shift;
            end
            par_valid_r <= par_done;
            abort_r     <= abort_set;
        end
    end

    assign fifo_wr    = msg_take && word_done;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (AW + 1)'(FIFO_DEPTH));
    assign fifo_rd    = !fifo_empty && bus.msg_ready;
    // A full FIFO still accepts a word when the head leaves in the same edge.
    assign fifo_wr_ok = fifo_wr && (!fifo_full || fifo_rd);

    // Message-word FIFO; a word arriving while full is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (fifo_wr_ok) begin
                mem[wr_ptr] <= word_shift;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({fifo_wr_ok, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: ;
            endcase
            if (fifo_wr && !fifo_wr_ok) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus.msg_word  = mem[rd_ptr];
    assign bus.msg_valid = !fifo_empty;
    assign bus.par_out   = par_out_r;
    assign bus.par_valid = par_valid_r;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.overflow  = overflow_r;
    assign bus.abort     = abort_r;
    assign state_dbg     = state;

`ifdef RX_PARITY_CHECK_EN
    logic        par_err_r;
    logic [15:0] err_cnt_r;
    logic        par_mismatch;

    assign par_mismatch = par_done && (par_shift != bus.exp_par);

    // Parity compare pulse alongside par_valid, plus saturating error count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_r <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            par_err_r <= par_mismatch;
            if (par_mismatch && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign bus.par_err = par_err_r;
    assign bus.err_cnt = err_cnt_r;
`endif
endmodule

// File: tb/tb_rce_codeword_receiver.sv
// Directed bench for rce_codeword_receiver (K=1024, K_N=256, W=32, depth 4).
// Honours RX_PARITY_CHECK_EN when it is defined.
module tb_rce_codeword_receiver;
    localparam logic [255:0] PAR_A5 = {32{8'hA5}};
    localparam logic [255:0] PAR_B  = {16{16'h1A2B}};
    localparam logic [255:0] PAR_C  = {8{32'h0F1E_2D3C}};
    localparam logic [255:0] PAR_D  = {4{64'h0123_4567_89AB_CDEF}};

    logic clk = 1'b0;
    logic rst;
    logic [1:0] state_dbg;

    rce_codeword_receiver_if #(.W(32), .K_N(256)) bus ();

    rce_codeword_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int          pv_cyc_q[$];
    int          checks = 0;
    int          errs   = 0;
    int          pv_cnt = 0;
    int          ab_cnt = 0;
    int          pop_cnt = 0;
    int          sof_cyc = 0;
    int          pv0, ab0, pop0, s0;
`ifdef RX_PARITY_CHECK_EN
    logic [255:0] par_flip = '0;
    logic         pe_last = 1'b0;
`endif

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample away from the rising edge: pulses, and words accepted at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.par_valid) begin
                pv_cnt++;
                pv_cyc_q.push_back(cyc);
`ifdef RX_PARITY_CHECK_EN
                pe_last = bus.par_err;
`endif
            end
            if (bus.abort) ab_cnt++;
            if (bus.msg_valid && bus.msg_ready) begin
                chk("msg_avail", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) chk("msg_word", 256'(bus.msg_word), 256'(exp_q.pop_front()));
                pop_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives frame bits [from..to]; bit 0 carries sof. Message word i is
    // seed + step*i. Words with index < push_n are expected at the output.
    task automatic send_bits(input logic [31:0] seed, input logic [31:0] step,
                             input logic [255:0] par, input int from, input int to,
                             input bit toggle, input int push_n);
        logic [31:0] w;
        for (int i = from; i <= to; i++) begin
            w = seed + step * 32'(i / 32);
            if (i < 1024) bus.y = w[31 - (i % 32)];
            else          bus.y = par[255 - (i - 1024)];
            bus.bit_en = 1'b1;
            bus.sof    = (i == 0);
`ifdef RX_PARITY_CHECK_EN
            bus.exp_par = par ^ par_flip;
`endif
            if (i == 0) sof_cyc = cyc;
            if (i < 1024 && (i % 32) == 31 && (i / 32) < push_n) exp_q.push_back(w);
            @(posedge clk); #1;
            if (toggle) begin
                bus.bit_en = 1'b0;
                bus.y      = 1'($urandom_range(0, 1));
                bus.sof    = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        bus.bit_en = 1'b0;
        bus.sof    = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.bit_en = 1'b0;
        bus.sof    = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 256'(exp_q.size()), 256'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic mark();
        pv0 = pv_cnt; ab0 = ab_cnt; pop0 = pop_cnt;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        bus.y = 1'b0; bus.bit_en = 1'b0; bus.sof = 1'b0; bus.msg_ready = 1'b1;
`ifdef RX_PARITY_CHECK_EN
        bus.exp_par = '0;
`endif
        #1;
        chk("rst_msg_valid", 256'(bus.msg_valid), 256'(0));
        chk("rst_msg_word",  256'(bus.msg_word),  256'(0));
        chk("rst_par_out",   bus.par_out,         256'(0));
        chk("rst_par_valid", 256'(bus.par_valid), 256'(0));
        chk("rst_busy",      256'(bus.busy),      256'(0));
        chk("rst_overflow",  256'(bus.overflow),  256'(0));
        chk("rst_abort",     256'(bus.abort),     256'(0));
        chk("rst_state",     256'(state_dbg),     256'(0));
        do_reset();

        // bit_en without sof in IDLE is ignored
        repeat (6) begin
            bus.bit_en = 1'b1; bus.sof = 1'b0; bus.y = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        idle(1);
        chk("idle_busy",      256'(bus.busy),      256'(0));
        chk("idle_msg_valid", 256'(bus.msg_valid), 256'(0));

        // T1: continuous frame, DEADBEEF words, A5 parity
        mark();
        send_bits(32'hDEADBEEF, 32'h0, PAR_A5, 0, 600, 0, 32);
        s0 = sof_cyc;
        chk("t1_busy_msg",  256'(bus.busy),  256'(1));
        chk("t1_state_msg", 256'(state_dbg), 256'(1));
        send_bits(32'hDEADBEEF, 32'h0, PAR_A5, 601, 1100, 0, 32);
        chk("t1_state_par", 256'(state_dbg), 256'(2));
        send_bits(32'hDEADBEEF, 32'h0, PAR_A5, 1101, 1279, 0, 32);
        chk("t1_par_valid", 256'(bus.par_valid), 256'(1));
        chk("t1_par_out",   bus.par_out,         PAR_A5);
        chk("t1_busy_end",  256'(bus.busy),      256'(0));
        idle(3);
        chk("t1_pv_pulses", 256'(pv_cnt - pv0), 256'(1));
        // par_valid is seen in clock 1281 when the sof clock is clock 1
        chk("t1_pv_latency", 256'(pv_cyc_q[$] - s0 + 1), 256'(1281));
        drain("t1_drain");
        chk("t1_words", 256'(pop_cnt - pop0), 256'(32));

        // T2: same frame with bit_en toggling; off cycles carry junk y/sof
        mark();
        send_bits(32'hDEADBEEF, 32'h0, PAR_A5, 0, 1279, 1, 32);
        s0 = sof_cyc;
        idle(3);
        chk("t2_pv_pulses", 256'(pv_cnt - pv0), 256'(1));
        chk("t2_par_out",   bus.par_out,         PAR_A5);
        // last bit enters at clock 2559 (sof clock = 1); par_valid one clock later
        chk("t2_pv_latency", 256'(pv_cyc_q[$] - s0 + 1), 256'(2560));
        chk("t2_no_abort",   256'(ab_cnt - ab0), 256'(0));
        drain("t2_drain");
        chk("t2_words", 256'(pop_cnt - pop0), 256'(32));

        // T3: sof again at message bit 500 -> abort, words 0-14 kept
        mark();
        send_bits(32'h1234_5678, 32'h0101_0101, PAR_B, 0, 499, 0, 15);
        send_bits(32'hCAFE_0000, 32'h0000_0011, PAR_C, 0, 1279, 0, 32);
        idle(3);
        chk("t3_abort",     256'(ab_cnt - ab0), 256'(1));
        chk("t3_pv_pulses", 256'(pv_cnt - pv0), 256'(1));
        chk("t3_par_out",   bus.par_out,        PAR_C);
        drain("t3_drain");
        chk("t3_words", 256'(pop_cnt - pop0), 256'(47));

        // T4: back-to-back frames, no gap
        mark();
        send_bits(32'hA000_0001, 32'h0000_0100, PAR_B, 0, 1279, 0, 32);
        send_bits(32'hB000_0002, 32'h0001_0000, PAR_D, 0, 1279, 0, 32);
        idle(3);
        chk("t4_pv_pulses", 256'(pv_cnt - pv0), 256'(2));
        chk("t4_pv_gap",    256'(pv_cyc_q[$] - pv_cyc_q[$-1]), 256'(1280));
        chk("t4_no_abort",  256'(ab_cnt - ab0), 256'(0));
        chk("t4_par_out",   bus.par_out,        PAR_D);
        drain("t4_drain");
        chk("t4_words", 256'(pop_cnt - pop0), 256'(64));

        // T5: consumer stalled for whole frame -> 4 kept, overflow on 5th
        mark();
        bus.msg_ready = 1'b0;
        send_bits(32'h5555_0000, 32'h0000_0001, PAR_C, 0, 158, 0, 4);
        chk("t5_ovf_before", 256'(bus.overflow),  256'(0));
        chk("t5_head_word",  256'(bus.msg_word),  256'(32'h5555_0000));
        send_bits(32'h5555_0000, 32'h0000_0001, PAR_C, 159, 159, 0, 4);
        chk("t5_ovf_after",  256'(bus.overflow),  256'(1));
        send_bits(32'h5555_0000, 32'h0000_0001, PAR_C, 160, 1279, 0, 4);
        idle(2);
        chk("t5_par_out", bus.par_out, PAR_C);
        bus.msg_ready = 1'b1;
        drain("t5_drain");
        idle(2);
        chk("t5_words",       256'(pop_cnt - pop0),  256'(4));
        chk("t5_empty",       256'(bus.msg_valid),   256'(0));
        chk("t5_ovf_sticky",  256'(bus.overflow),    256'(1));

        // T6: asynchronous reset mid-PAR, then a clean frame
        mark();
        send_bits(32'h7777_0000, 32'h0000_0003, PAR_B, 0, 1100, 0, 32);
        drain("t6_pre_drain");
        #2 rst = 1'b1;
        #1;
        chk("t6_busy",      256'(bus.busy),      256'(0));
        chk("t6_par_out",   bus.par_out,         256'(0));
        chk("t6_par_valid", 256'(bus.par_valid), 256'(0));
        chk("t6_overflow",  256'(bus.overflow),  256'(0));
        chk("t6_msg_valid", 256'(bus.msg_valid), 256'(0));
        chk("t6_state",     256'(state_dbg),     256'(0));
        @(posedge clk); #1 rst = 1'b0;
        pop0 = pop_cnt;
`ifdef RX_PARITY_CHECK_EN
        par_flip = 256'(1);
`endif
        send_bits(32'h3C3C_0000, 32'h0000_0101, PAR_D, 0, 1279, 0, 32);
        idle(3);
        chk("t6_pv_pulses", 256'(pv_cnt - pv0), 256'(1));
        chk("t6_no_abort",  256'(ab_cnt - ab0), 256'(0));
        chk("t6_par_new",   bus.par_out,        PAR_D);
`ifdef RX_PARITY_CHECK_EN
        chk("t6_par_err", 256'(pe_last),     256'(1));
        chk("t6_err_cnt", 256'(bus.err_cnt), 256'(1));
`endif
        drain("t6_drain");
        chk("t6_words", 256'(pop_cnt - pop0), 256'(32));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
        $fatal(1, "timeout");
    end
endmodule
